arbiter_rr_tree: RTL and testbench
==================================

Name: arbiter_rr_tree

Overview:
- N-input clocked arbiter cell using the four-phase request/acknowledge protocol. It is the parametrised successor of the two-input tree arbiter cell.
- Collects local requests `req[N-1:0]` and forwards one merged request upstream on `req_up`. When `ack_up` arrives, it grants exactly one requester.
- Cells cascade into arbitration trees by connecting `req_up`/`ack_up` to a parent cell's `req[i]`/`grant[i]`.
- Adds round-robin fairness, a selectable fixed-priority mode and optional input synchronisers.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority, lowest index wins.
- SYNC_STAGES, 0, flop stages on `req` and `ack_up` before use; legal values 0, 2, 3.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester four-phase request.
- grant  out  N_REQ  one-hot acknowledge to requesters; registered.
- req_up  out  1  merged request to the parent cell; registered.
- ack_up  in  1  acknowledge from the parent cell.
- grant_id  out  clog2(N_REQ)  binary index of the active grant; 0 when `grant` == 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset state:
  - Asserting `rst` immediately forces `grant`=0, `req_up`=0, `grant_id`=0, `busy`=0, state=IDLE and pointer=0, with no clock edge required.
  - Deassertion is sampled at the next clock edge.
- Input synchronisers: `req` and `ack_up` are used after SYNC_STAGES flops. Every latency below grows by SYNC_STAGES cycles.
- State machine: IDLE, UP_REQ, GRANT, RELEASE.
  - IDLE -> UP_REQ: when `|req` and `ack_up`==0.
    - The winner `w` is latched on this edge.
    - `req_up`=1 from the next cycle.
    - If `ack_up` is still high from a previous cycle, stay in IDLE with `req_up`=0.
  - UP_REQ -> GRANT: when `ack_up`==1 and `req[w]`==1. `grant[w]`=1 and `grant_id`=w from the next cycle.
  - UP_REQ -> RELEASE: when `ack_up`==1 and `req[w]`==0 (requester withdrew). No grant is issued; `req_up`=0 next cycle.
  - GRANT -> RELEASE: when `req[w]`==0. `grant`=0, `grant_id`=0 and `req_up`=0 next cycle. The pointer updates on this edge.
  - RELEASE -> IDLE: when `ack_up`==0.
- Winner selection:
  - ROUND_ROBIN=1: scan for the first asserted `req` starting at the pointer index and wrapping modulo N_REQ.
  - ROUND_ROBIN=0: lowest asserted index.
- Pointer rule:
  - On leaving GRANT, or on leaving UP_REQ via withdrawal, pointer = (w+1) mod N_REQ.
  - Wrap from N_REQ-1 to 0.
  - Unused in fixed-priority mode.
- Minimum latency with SYNC_STAGES=0:
  - `req` sampled high -> `req_up` high: 1 cycle.
  - `ack_up` sampled high -> `grant` high: 1 cycle.
  - `req[w]` sampled low -> `grant` and `req_up` low: 1 cycle.
- Back-to-back handshakes: at least one IDLE cycle separates consecutive grants.
- Non-winner requests:
  - Ignored while busy.
  - Other requests changing during UP_REQ/GRANT do not change `w`.
  - A request that drops before being chosen is simply not granted.
- Invariants:
  - `grant` is always one-hot or zero.
  - `grant`!=0 only in GRANT.
  - `req_up` is high only in UP_REQ and GRANT.
- Protocol misuse: `ack_up` falling while in GRANT is a protocol error. The cell holds GRANT; no recovery is attempted.

Test Plan:
- N_REQ=4, RR. Reset pulse mid-test while in GRANT with `grant`=0100 -> `grant`, `req_up`, `busy` go 0 before the next clk edge; the next arbitration starts at pointer 0.
- `req`=0001. Parent raises `ack_up` 2 cycles after `req_up` -> `req_up` 1 cycle after `req`; `grant`=0001 and `grant_id`=0 1 cycle after `ack_up`; `req` drops -> `grant`=0, `req_up`=0 next cycle; `ack_up` low -> IDLE.
- `req`=1111 held throughout, with each requester dropping after its grant and reasserting -> grant order 0,1,2,3,0, with `grant_id` matching each grant.
- ROUND_ROBIN=0, `req`=1010 repeated for 4 handshakes -> `grant`=0010 every time.
- `ack_up` held at 1 while `req`=0100 -> `req_up` stays 0 until `ack_up`=0, then rises next cycle.
- `req`=0010 withdrawn to 0000 during UP_REQ, then `ack_up`=1 -> `grant` never asserts, `req_up` drops next cycle, pointer becomes 2.

Source files
------------

// File: rtl/arbiter_rr_tree.sv
// N-input four-phase request/acknowledge arbiter cell for cascading into trees.
// Selects one requester (round-robin or fixed priority), forwards a merged request and grants on ack_up.
module arbiter_rr_tree #(
  parameter int N_REQ       = 4,
  parameter int ROUND_ROBIN = 1,
  parameter int SYNC_STAGES = 0,
  localparam int IDW        = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             req_up,
  input  logic             ack_up,
  output logic [IDW-1:0]   grant_id,
  output logic             busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] UP_REQ  = 2'd1;
  localparam logic [1:0] GRANT   = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [N_REQ-1:0] req_s;
  logic             ack_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = req;
      assign ack_s = ack_up;
    end else begin : g_sync
      logic [N_REQ:0] sync_q [SYNC_STAGES];
      logic [N_REQ:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = {ack_up, req};
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_d[s] = sync_q[s-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
          end
        end else begin
          for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_d[s];
          end
        end
      end

      assign {ack_s, req_s} = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   winner_q, winner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             req_up_q, req_up_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;

  logic             sel_found;
  logic [IDW-1:0]   sel_idx;
  int               scan_idx;
  logic [IDW-1:0]   ptr_inc;

  // Scan starts at the pointer in round-robin mode, at index 0 in fixed-priority mode.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = (ROUND_ROBIN != 0) ? int'(ptr_q) + i : i;
      if (scan_idx >= N_REQ) begin
        scan_idx = scan_idx - N_REQ;
      end
      if (!sel_found && req_s[scan_idx[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx[IDW-1:0];
      end
    end
  end

  assign ptr_inc = (winner_q == IDW'(N_REQ - 1)) ? '0 : winner_q + IDW'(1);

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    req_up_d   = req_up_q;
    grant_id_d = grant_id_q;
    case (state_q)
      IDLE: begin
        if (sel_found && !ack_s) begin
          state_d  = UP_REQ;
          winner_d = sel_idx;
          req_up_d = 1'b1;
        end
      end
      UP_REQ: begin
        if (ack_s) begin
          if (req_s[winner_q]) begin
            state_d           = GRANT;
            grant_d           = '0;
            grant_d[winner_q] = 1'b1;
            grant_id_d        = winner_q;
          end else begin
            state_d  = RELEASE;
            req_up_d = 1'b0;
            if (ROUND_ROBIN != 0) ptr_d = ptr_inc;
          end
        end
      end
      // A falling ack_up here is a parent protocol error; the cell simply holds.
      GRANT: begin
        if (!req_s[winner_q]) begin
          state_d    = RELEASE;
          grant_d    = '0;
          grant_id_d = '0;
          req_up_d   = 1'b0;
          if (ROUND_ROBIN != 0) ptr_d = ptr_inc;
        end
      end
      default: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      winner_q   <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      req_up_q   <= 1'b0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      req_up_q   <= req_up_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign grant    = grant_q;
  assign req_up   = req_up_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_arbiter_rr_tree.sv
// Table-driven bench for arbiter_rr_tree: one round-robin and one fixed-priority instance.
// Expected outputs are queued when a vector is driven and compared one cycle later.
module tb_arbiter_rr_tree;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_rr = '0, req_fp = '0;
  logic       ack_rr = 1'b0, ack_fp = 1'b0;
  logic [3:0] grant_rr, grant_fp;
  logic       req_up_rr, req_up_fp, busy_rr, busy_fp;
  logic [1:0] id_rr, id_fp;

  always #5 clk = ~clk;

  arbiter_rr_tree #(.N_REQ(4), .ROUND_ROBIN(1), .SYNC_STAGES(0)) dut_rr (
    .clk(clk), .rst(rst), .req(req_rr), .grant(grant_rr), .req_up(req_up_rr),
    .ack_up(ack_rr), .grant_id(id_rr), .busy(busy_rr)
  );

  arbiter_rr_tree #(.N_REQ(4), .ROUND_ROBIN(0), .SYNC_STAGES(0)) dut_fp (
    .clk(clk), .rst(rst), .req(req_fp), .grant(grant_fp), .req_up(req_up_fp),
    .ack_up(ack_fp), .grant_id(id_fp), .busy(busy_fp)
  );

  typedef struct {
    logic       sel;
    logic [3:0] req;
    logic       ack;
    logic [3:0] grant;
    logic       req_up;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [3:0] grant;
    logic       req_up;
    logic [1:0] id;
    logic       busy;
    int         tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   split_idx;

  function automatic vec_t mk(input logic sel, input logic [3:0] r, input logic a,
                              input logic [3:0] g, input logic ru, input logic [1:0] id,
                              input logic b);
    vec_t v;
    v.sel = sel; v.req = r; v.ack = a; v.grant = g; v.req_up = ru; v.id = id; v.busy = b;
    return v;
  endfunction

  task automatic checkValue(input string name, input int tag, input logic [3:0] act,
                            input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %b expected %b", name, tag, act, exp);
    end
  endtask

  // One full handshake: request, parent ack, requester k drops, parent releases.
  task automatic addHandshake(input logic sel, input logic [3:0] req_hi,
                              input logic [3:0] req_lo, input int k);
    logic [3:0] g;
    g = 4'b0001 << k;
    vecs.push_back(mk(sel, req_hi, 1'b0, 4'b0000, 1'b1, 2'd0,     1'b1));
    vecs.push_back(mk(sel, req_hi, 1'b1, g,       1'b1, 2'(k),    1'b1));
    vecs.push_back(mk(sel, req_lo, 1'b1, 4'b0000, 1'b0, 2'd0,     1'b1));
    vecs.push_back(mk(sel, req_hi, 1'b0, 4'b0000, 1'b0, 2'd0,     1'b0));
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard empty: got none expected entry");
      return;
    end
    e = sb.pop_front();
    if (e.sel == 1'b0) begin
      checkValue("grant",    e.tag, grant_rr,            e.grant);
      checkValue("req_up",   e.tag, {3'b000, req_up_rr}, {3'b000, e.req_up});
      checkValue("grant_id", e.tag, {2'b00, id_rr},      {2'b00, e.id});
      checkValue("busy",     e.tag, {3'b000, busy_rr},   {3'b000, e.busy});
    end else begin
      checkValue("fp_grant",    e.tag, grant_fp,            e.grant);
      checkValue("fp_req_up",   e.tag, {3'b000, req_up_fp}, {3'b000, e.req_up});
      checkValue("fp_grant_id", e.tag, {2'b00, id_fp},      {2'b00, e.id});
      checkValue("fp_busy",     e.tag, {3'b000, busy_fp},   {3'b000, e.busy});
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int tag);
    exp_t e;
    @(negedge clk);
    if (v.sel == 1'b0) begin
      req_rr = v.req; ack_rr = v.ack; req_fp = '0; ack_fp = 1'b0;
    end else begin
      req_fp = v.req; ack_fp = v.ack; req_rr = '0; ack_rr = 1'b0;
    end
    e.sel = v.sel; e.grant = v.grant; e.req_up = v.req_up; e.id = v.id; e.busy = v.busy; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Called just after the edge that left dut_rr in GRANT with grant=0100.
  task automatic resetMidGrant();
    #2;
    rst = 1'b1;
    #1;
    checkValue("async_rst_grant",  -1, grant_rr,            4'b0000);
    checkValue("async_rst_req_up", -1, {3'b000, req_up_rr}, 4'b0000);
    checkValue("async_rst_id",     -1, {2'b00, id_rr},      4'b0000);
    checkValue("async_rst_busy",   -1, {3'b000, busy_rr},   4'b0000);
    req_rr = '0;
    ack_rr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Round-robin from pointer 0 with all four requesting: order 0,1,2,3,0.
    addHandshake(1'b0, 4'b1111, 4'b1110, 0);
    addHandshake(1'b0, 4'b1111, 4'b1101, 1);
    addHandshake(1'b0, 4'b1111, 4'b1011, 2);
    addHandshake(1'b0, 4'b1111, 4'b0111, 3);
    addHandshake(1'b0, 4'b1111, 4'b1110, 0);
    // Single requester 0 with ack arriving two cycles after req_up.
    vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0));
    // Stale ack_up holds the cell in IDLE; then requester 2 is granted.
    vecs.push_back(mk(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1));
    split_idx = vecs.size();
    // After reset the pointer is back at 0.
    addHandshake(1'b0, 4'b1111, 4'b1110, 0);
    // Requester 1 withdraws during UP_REQ: no grant, pointer moves to 2.
    vecs.push_back(mk(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0));
    addHandshake(1'b0, 4'b1111, 4'b1011, 2);
    // Fixed priority: 1010 always resolves to requester 1.
    for (int n = 0; n < 4; n++) begin
      addHandshake(1'b1, 4'b1010, 4'b1000, 1);
    end

    #1;
    rst = 1'b1;
    #1;
    checkValue("reset_grant",    -1, grant_rr,            4'b0000);
    checkValue("reset_req_up",   -1, {3'b000, req_up_rr}, 4'b0000);
    checkValue("reset_id",       -1, {2'b00, id_rr},      4'b0000);
    checkValue("reset_busy",     -1, {3'b000, busy_rr},   4'b0000);
    checkValue("reset_fp_grant", -1, grant_fp,            4'b0000);
    checkValue("reset_fp_busy",  -1, {3'b000, busy_fp},   4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == split_idx) begin
        resetMidGrant();
      end
      applyStimulus(vecs[i], i);
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
